fetch_stage: RTL and testbench

Instruction-fetch stage of the PMIPSL0 datapath: holds the program counter, drives the instruction-memory address, and captures the fetched instruction into the IF/ID pipeline register whose opcode field feeds the controller. It obeys the controller's PCControl encoding (Stall / Inc / CondLoad) and takes jump and taken-branch redirects from the memory-access stage. Two sticky error flags and a fetch counter support debug and verification.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage_pc_next_sel.sv | 45 ++++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared PMIPSL0 constants: PCControl encoding, opcode field position, instruction size.
// Imported by the fetch stage, its next-PC selector and the interface users.
package pmipsl0_pkg;

    localparam logic [1:0] PC_STALL    = 2'd0;
    localparam logic [1:0] PC_INC      = 2'd1;
    localparam logic [1:0] PC_CONDLOAD = 2'd2;
    localparam logic [1:0] PC_RESERVED = 2'd3;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 12;
    localparam int INSTR_BYTES = 2;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: controller/MEM-stage inputs, instruction memory port, IF/ID outputs and debug flags.
// master = surrounding datapath, slave = fetch stage.
interface fetch_stage_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       pc_control;
    logic             jump_taken;
    logic [WIDTH-1:0] jump_addr;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_addr;
    logic [WIDTH-1:0] imem_data;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ifid_instr;
    logic [WIDTH-1:0] ifid_pc_plus2;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] fetch_count;
    logic             err_ctrl;
    logic             err_misalign;

    modport master (
        output pc_control, jump_taken, jump_addr, branch_taken, branch_addr, imem_data,
        input  pc, ifid_instr, ifid_pc_plus2, opcode, fetch_count, err_ctrl, err_misalign
    );

    modport slave (
        input  pc_control, jump_taken, jump_addr, branch_taken, branch_addr, imem_data,
        output pc, ifid_instr, ifid_pc_plus2, opcode, fetch_count, err_ctrl, err_misalign
    );
endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC selection: Inc adds one instruction, CondLoad takes jump before branch.
// Redirect targets are forced even; an odd target raises misalign_o alongside the load.
module pc_next_sel
    import pmipsl0_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic [1:0]       pc_control_i,
    input  logic             jump_taken_i,
    input  logic [WIDTH-1:0] jump_addr_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_addr_i,
    output logic [WIDTH-1:0] pc_next_o,
    output logic             load_en_o,
    output logic             misalign_o
);

    always_comb begin
        pc_next_o  = pc_i;
        load_en_o  = 1'b0;
        misalign_o = 1'b0;
        case (pc_control_i)
            PC_INC: begin
                pc_next_o = pc_i + WIDTH'(INSTR_BYTES);
                load_en_o = 1'b1;
            end
            PC_CONDLOAD: begin
                // Take flags are only meaningful here; jump outranks branch.
                if (jump_taken_i) begin
                    pc_next_o  = {jump_addr_i[WIDTH-1:1], 1'b0};
                    load_en_o  = 1'b1;
                    misalign_o = jump_addr_i[0];
                end else if (branch_taken_i) begin
                    pc_next_o  = {branch_addr_i[WIDTH-1:1], 1'b0};
                    load_en_o  = 1'b1;
                    misalign_o = branch_addr_i[0];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// PMIPSL0 instruction fetch: PC register, IF/ID register, fetch counter and sticky error flags.
// Every output registered (opcode is a slice of IF/ID); reset has priority and discards redirects.
module fetch_stage
    import pmipsl0_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic         clock,
    input logic         reset,
    fetch_stage_if.slave bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [WIDTH-1:0] ifid_pc_plus2_q, ifid_pc_plus2_d;
    logic [WIDTH-1:0] fetch_count_q, fetch_count_d;
    logic             err_ctrl_q, err_ctrl_d;
    logic             err_misalign_q, err_misalign_d;

    logic [WIDTH-1:0] pc_next;
    logic             load_en;
    logic             misalign;
    logic             inc;

    pc_next_sel #(.WIDTH(WIDTH)) u_pc_next_sel (
        .pc_i           (pc_q),
        .pc_control_i   (bus.pc_control),
        .jump_taken_i   (bus.jump_taken),
        .jump_addr_i    (bus.jump_addr),
        .branch_taken_i (bus.branch_taken),
        .branch_addr_i  (bus.branch_addr),
        .pc_next_o      (pc_next),
        .load_en_o      (load_en),
        .misalign_o     (misalign)
    );

    assign inc = (bus.pc_control == PC_INC);

    always_comb begin
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus2_d = ifid_pc_plus2_q;
        fetch_count_d   = fetch_count_q;
        err_ctrl_d      = err_ctrl_q | (bus.pc_control == PC_RESERVED);
        err_misalign_d  = err_misalign_q | misalign;

        if (load_en) begin
            pc_d = pc_next;
        end
        // On Inc the selector's next PC is exactly PC+2, reused for the IF/ID copy.
        if (inc) begin
            ifid_instr_d    = bus.imem_data;
            ifid_pc_plus2_d = pc_next;
            fetch_count_d   = fetch_count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            ifid_instr_q    <= '0;
            ifid_pc_plus2_q <= '0;
            fetch_count_q   <= '0;
            err_ctrl_q      <= 1'b0;
            err_misalign_q  <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus2_q <= ifid_pc_plus2_d;
            fetch_count_q   <= fetch_count_d;
            err_ctrl_q      <= err_ctrl_d;
            err_misalign_q  <= err_misalign_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.ifid_instr    = ifid_instr_q;
    assign bus.ifid_pc_plus2 = ifid_pc_plus2_q;
    assign bus.opcode        = ifid_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.fetch_count   = fetch_count_q;
    assign bus.err_ctrl      = err_ctrl_q;
    assign bus.err_misalign  = err_misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;
    import pmipsl0_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_stage_if #(.WIDTH(16)) bus ();

    fetch_stage #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        imem_force_en;
    logic [15:0] imem_force;

    function automatic logic [15:0] imem_word(input logic [15:0] a);
        return 16'(a * 16'd40503) ^ 16'hC3A5;
    endfunction

    always_comb bus.imem_data = imem_force_en ? imem_force : imem_word(bus.pc);

    // Behavioural model state
    logic [15:0] m_pc, m_instr, m_p2, m_cnt;
    logic        m_ectl, m_emis;
    logic        m_valid = 1'b0;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            check("pc", bus.pc, m_pc);
            check("ifid_instr", bus.ifid_instr, m_instr);
            check("ifid_pc_plus2", bus.ifid_pc_plus2, m_p2);
            check("opcode", 16'(bus.opcode), 16'(m_instr[15:12]));
            check("fetch_count", bus.fetch_count, m_cnt);
            check("err_ctrl", 16'(bus.err_ctrl), 16'(m_ectl));
            check("err_misalign", 16'(bus.err_misalign), 16'(m_emis));
        end
    end

    // One clock with the given inputs; the model advances at the same edge as the DUT.
    task automatic cyc(input logic r, input logic [1:0] c, input logic jt, input logic [15:0] ja,
                       input logic bt, input logic [15:0] ba);
        logic [15:0] im;
        reset            = r;
        bus.pc_control   = c;
        bus.jump_taken   = jt;
        bus.jump_addr    = ja;
        bus.branch_taken = bt;
        bus.branch_addr  = ba;
        @(posedge clock);
        im = imem_force_en ? imem_force : imem_word(m_pc);
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_p2 = 16'h0000; m_cnt = 16'h0000;
            m_ectl = 1'b0; m_emis = 1'b0;
            m_valid = 1'b1;
        end else if (c == 2'd1) begin
            m_instr = im;
            m_pc    = m_pc + 16'd2;
            m_p2    = m_pc;
            m_cnt   = m_cnt + 16'd1;
        end else if (c == 2'd2) begin
            if (jt) begin
                m_pc = ja & 16'hFFFE;
                if (ja % 2 == 1) m_emis = 1'b1;
            end else if (bt) begin
                m_pc = ba & 16'hFFFE;
                if (ba % 2 == 1) m_emis = 1'b1;
            end
        end else if (c == 2'd3) begin
            m_ectl = 1'b1;
        end
        @(negedge clock);
    endtask

    initial begin
        imem_force_en    = 1'b1;
        imem_force       = 16'h3123;
        reset            = 1'b1;
        bus.pc_control   = PC_STALL;
        bus.jump_taken   = 1'b0;
        bus.jump_addr    = '0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = '0;

        cyc(1, PC_STALL, 0, 0, 0, 0);
        cyc(1, PC_STALL, 0, 0, 0, 0);
        check("reset_pc", bus.pc, 16'h0000);
        check("reset_count", bus.fetch_count, 16'h0000);
        check("reset_instr", bus.ifid_instr, 16'h0000);

        // Single Inc
        cyc(0, PC_INC, 0, 0, 0, 0);
        check("inc_pc", bus.pc, 16'h0002);
        check("inc_instr", bus.ifid_instr, 16'h3123);
        check("inc_opcode", 16'(bus.opcode), 16'h0003);
        check("inc_pc_plus2", bus.ifid_pc_plus2, 16'h0002);
        check("inc_count", bus.fetch_count, 16'h0001);

        // Stall and wrap
        cyc(0, PC_CONDLOAD, 1, 16'hFFFE, 0, 0);
        check("wrap_load", bus.pc, 16'hFFFE);
        cyc(0, PC_STALL, 0, 0, 0, 0);
        check("stall1_pc", bus.pc, 16'hFFFE);
        cyc(0, PC_STALL, 0, 0, 0, 0);
        check("stall2_pc", bus.pc, 16'hFFFE);
        cyc(0, PC_INC, 0, 0, 0, 0);
        check("wrap_pc", bus.pc, 16'h0000);
        check("wrap_pc_plus2", bus.ifid_pc_plus2, 16'h0000);
        check("wrap_count", bus.fetch_count, 16'h0002);

        // Redirect priority
        cyc(0, PC_CONDLOAD, 1, 16'h0040, 1, 16'h0080);
        check("prio_jump", bus.pc, 16'h0040);
        cyc(0, PC_CONDLOAD, 0, 16'h0040, 1, 16'h0080);
        check("prio_branch", bus.pc, 16'h0080);
        cyc(0, PC_CONDLOAD, 0, 16'h0040, 0, 16'h0080);
        check("prio_none", bus.pc, 16'h0080);
        check("condload_count", bus.fetch_count, 16'h0002);

        // Misaligned target
        cyc(0, PC_CONDLOAD, 0, 0, 1, 16'h0013);
        check("misalign_pc", bus.pc, 16'h0012);
        check("misalign_flag", 16'(bus.err_misalign), 16'h0001);
        cyc(0, PC_INC, 0, 0, 0, 0);
        cyc(0, PC_STALL, 0, 0, 0, 0);
        check("misalign_sticky", 16'(bus.err_misalign), 16'h0001);
        check("misalign_next_pc", bus.pc, 16'h0014);

        // Reserved control, then Inc with a stray jump
        cyc(0, PC_RESERVED, 1, 16'h0100, 0, 0);
        check("reserved_pc", bus.pc, 16'h0014);
        check("reserved_flag", 16'(bus.err_ctrl), 16'h0001);
        cyc(0, PC_INC, 1, 16'h0100, 1, 16'h0200);
        check("stray_jump_pc", bus.pc, 16'h0016);
        check("reserved_sticky", 16'(bus.err_ctrl), 16'h0001);

        // Reset during a taken CondLoad
        cyc(1, PC_CONDLOAD, 1, 16'h0200, 1, 16'h0300);
        check("midreset_pc", bus.pc, 16'h0000);
        check("midreset_instr", bus.ifid_instr, 16'h0000);
        check("midreset_pc_plus2", bus.ifid_pc_plus2, 16'h0000);
        check("midreset_count", bus.fetch_count, 16'h0000);
        check("midreset_err_ctrl", 16'(bus.err_ctrl), 16'h0000);
        check("midreset_err_misalign", 16'(bus.err_misalign), 16'h0000);

        // Randomized traffic
        imem_force_en = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [1:0]  c;
            int          v;
            logic [15:0] ja, ba;
            r = ($urandom_range(0, 199) == 0);
            v = $urandom_range(0, 15);
            c = (v < 7) ? PC_INC : (v < 11) ? PC_STALL : (v < 15) ? PC_CONDLOAD : PC_RESERVED;
            ja = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom);
            ba = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                ja[0] = 1'b0;
                ba[0] = 1'b0;
            end
            cyc(r, c, 1'($urandom_range(0, 1)), ja, 1'($urandom_range(0, 1)), ba);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
